butterfly_stream: RTL

BUTTERFLY_STREAM -- requirements
Module: butterfly_stream

---
 rtl/butterfly_stream.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/butterfly_stream.sv
// Streaming radix-2 complex butterfly: Y = A + W*B, Z = A - W*B, 4-stage pipeline with valid/ready.
// Define BUTTERFLY_STREAM_SAT_EN to saturate out-of-range results; otherwise they wrap.
module butterfly_stream #(
    parameter int DATA_W = 8,
    parameter int FRAC_W = 7
) (
    input  logic              clk,
    input  logic              nreset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] a_re,
    input  logic [DATA_W-1:0] a_im,
    input  logic [DATA_W-1:0] b_re,
    input  logic [DATA_W-1:0] b_im,
    input  logic [DATA_W-1:0] w_re,
    input  logic [DATA_W-1:0] w_im,
    input  logic              scale,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] y_re,
    output logic [DATA_W-1:0] y_im,
    output logic [DATA_W-1:0] z_re,
    output logic [DATA_W-1:0] z_im,
    output logic              ovf,
    input  logic              ovf_clr
);

    localparam int PW = 2 * DATA_W;
    localparam int TW = 2 * DATA_W + 1;
    // Sums are kept wide enough that nothing wraps before the range check, whatever FRAC_W is.
    localparam int SW = 2 * DATA_W + 2;

    localparam logic signed [TW-1:0] RND  = TW'(1) <<< (FRAC_W - 1);
    localparam logic signed [SW-1:0] MAXV = (SW'(1) <<< (DATA_W - 1)) - SW'(1);
    localparam logic signed [SW-1:0] MINV = -MAXV - SW'(1);

    logic stall;

    logic                     s1_valid, s1_scale;
    logic signed [DATA_W-1:0] s1_a_re, s1_a_im, s1_b_re, s1_b_im, s1_w_re, s1_w_im;

    logic                     s2_valid, s2_scale;
    logic signed [DATA_W-1:0] s2_a_re, s2_a_im;
    logic signed [PW-1:0]     s2_p_rr, s2_p_ii, s2_p_ri, s2_p_ir;

    logic                     s3_valid, s3_scale;
    logic signed [DATA_W-1:0] s3_a_re, s3_a_im;
    logic signed [TW-1:0]     s3_t_re, s3_t_im;

    logic signed [TW-1:0]     t_re_full, t_im_full;
    logic signed [SW-1:0]     sum_w [4];
    logic signed [SW-1:0]     val   [4];
    logic [DATA_W-1:0]        lim   [4];
    logic [3:0]               oor;
    logic                     ovf_cond;
    logic                     ovf_evt;

    assign stall    = out_valid & ~out_ready;
    assign in_ready = ~stall;

    // S1: operand registers
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            s1_valid <= 1'b0;
            s1_scale <= 1'b0;
            s1_a_re  <= '0;
            s1_a_im  <= '0;
            s1_b_re  <= '0;
            s1_b_im  <= '0;
            s1_w_re  <= '0;
            s1_w_im  <= '0;
        end else if (!stall) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_scale <= scale;
                s1_a_re  <= a_re;
                s1_a_im  <= a_im;
                s1_b_re  <= b_re;
                s1_b_im  <= b_im;
                s1_w_re  <= w_re;
                s1_w_im  <= w_im;
            end
        end
    end

    // S2: four full-precision products
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            s2_valid <= 1'b0;
            s2_scale <= 1'b0;
            s2_a_re  <= '0;
            s2_a_im  <= '0;
            s2_p_rr  <= '0;
            s2_p_ii  <= '0;
            s2_p_ri  <= '0;
            s2_p_ir  <= '0;
        end else if (!stall) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_scale <= s1_scale;
                s2_a_re  <= s1_a_re;
                s2_a_im  <= s1_a_im;
                s2_p_rr  <= PW'(s1_w_re) * PW'(s1_b_re);
                s2_p_ii  <= PW'(s1_w_im) * PW'(s1_b_im);
                s2_p_ri  <= PW'(s1_w_re) * PW'(s1_b_im);
                s2_p_ir  <= PW'(s1_w_im) * PW'(s1_b_re);
            end
        end
    end

    always_comb begin
        t_re_full = TW'(s2_p_rr) - TW'(s2_p_ii);
        t_im_full = TW'(s2_p_ri) + TW'(s2_p_ir);
    end

    // S3: T = W*B, rounded half up to the data grid
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            s3_valid <= 1'b0;
            s3_scale <= 1'b0;
            s3_a_re  <= '0;
            s3_a_im  <= '0;
            s3_t_re  <= '0;
            s3_t_im  <= '0;
        end else if (!stall) begin
            s3_valid <= s2_valid;
            if (s2_valid) begin
                s3_scale <= s2_scale;
                s3_a_re  <= s2_a_re;
                s3_a_im  <= s2_a_im;
                s3_t_re  <= (t_re_full + RND) >>> FRAC_W;
                s3_t_im  <= (t_im_full + RND) >>> FRAC_W;
            end
        end
    end

    always_comb begin
        sum_w[0] = SW'(s3_a_re) + SW'(s3_t_re);
        sum_w[1] = SW'(s3_a_im) + SW'(s3_t_im);
        sum_w[2] = SW'(s3_a_re) - SW'(s3_t_re);
        sum_w[3] = SW'(s3_a_im) - SW'(s3_t_im);
        for (int i = 0; i < 4; i++) begin
            val[i] = s3_scale ? (sum_w[i] >>> 1) : sum_w[i];
            oor[i] = (val[i] > MAXV) || (val[i] < MINV);
`ifdef BUTTERFLY_STREAM_SAT_EN
            if (val[i] > MAXV)
                lim[i] = {1'b0, {(DATA_W-1){1'b1}}};
            else if (val[i] < MINV)
                lim[i] = {1'b1, {(DATA_W-1){1'b0}}};
            else
                lim[i] = val[i][DATA_W-1:0];
`else
            lim[i] = val[i][DATA_W-1:0];
`endif
        end
        ovf_cond = |oor;
    end

    // S4: output registers; ovf_evt marks the edge an overflowing result entered S4
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            out_valid <= 1'b0;
            y_re      <= '0;
            y_im      <= '0;
            z_re      <= '0;
            z_im      <= '0;
            ovf_evt   <= 1'b0;
        end else if (!stall) begin
            out_valid <= s3_valid;
            ovf_evt   <= s3_valid & ovf_cond;
            if (s3_valid) begin
                y_re <= lim[0];
                y_im <= lim[1];
                z_re <= lim[2];
                z_im <= lim[3];
            end
        end else begin
            ovf_evt <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset)
            ovf <= 1'b0;
        else if (ovf_evt)
            ovf <= 1'b1;
        else if (ovf_clr)
            ovf <= 1'b0;
    end

endmodule
